// File: rtl/oled_spi_arbiter_if.sv
// Requester handshakes and SPI pins of oled_spi_arbiter, grouped for port use.
interface oled_spi_arbiter_if;
    logic       cmd_req;
    logic [7:0] cmd_byte;
    logic       cmd_dc;
    logic       cmd_grant;
    logic       cmd_done;
    logic       pix_req;
    logic [7:0] pix_byte;
    logic       pix_last;
    logic       pix_grant;
    logic       pix_done;
    logic       SPI_CLK;
    logic       SPI_MOSI;
    logic       SPI_CS;
    logic       data_command;
    logic       busy;

    modport slave (
        input  cmd_req, cmd_byte, cmd_dc, pix_req, pix_byte, pix_last,
        output cmd_grant, cmd_done, pix_grant, pix_done,
               SPI_CLK, SPI_MOSI, SPI_CS, data_command, busy
    );

    modport master (
        output cmd_req, cmd_byte, cmd_dc, pix_req, pix_byte, pix_last,
        input  cmd_grant, cmd_done, pix_grant, pix_done,
               SPI_CLK, SPI_MOSI, SPI_CS, data_command, busy
    );
endinterface

// File: rtl/oled_spi_arbiter.sv
// SPI mode-3 arbiter for an OLED panel: command bytes versus locked pixel bursts.
// Define OLED_ARB_RR_EN for round-robin arbitration in IDLE instead of command-first.
module oled_spi_arbiter #(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    oled_spi_arbiter_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] half_q, half_d;
    logic [6:0] shreg_q, shreg_d;
    logic       owner_pix_q, owner_pix_d;
    logic       last_q, last_d;
    logic       lock_q, lock_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       cs_n_q, cs_n_d;
    logic       dc_q, dc_d;
    logic       cmd_grant_q, cmd_grant_d;
    logic       pix_grant_q, pix_grant_d;
    logic       cmd_done_q, cmd_done_d;
    logic       pix_done_q, pix_done_d;
    logic       cnt_end;
    logic       pick_cmd;
    logic       pick_pix;
    logic [7:0] byte_sel;

`ifdef OLED_ARB_RR_EN
    logic       prio_pix_q, prio_pix_d;
`endif

    assign cnt_end  = (cnt_q == DIV_LAST);
    assign byte_sel = pick_pix ? bus.pix_byte : bus.cmd_byte;

    // Full arbitration only in IDLE; a locked burst offers the bus to the pixel side alone.
    always_comb begin
        pick_cmd = 1'b0;
        pick_pix = 1'b0;
        if (state_q == IDLE) begin
`ifdef OLED_ARB_RR_EN
            if (bus.cmd_req && bus.pix_req) begin
                pick_cmd = !prio_pix_q;
                pick_pix = prio_pix_q;
            end else begin
                pick_cmd = bus.cmd_req;
                pick_pix = bus.pix_req;
            end
`else
            pick_cmd = bus.cmd_req;
            pick_pix = bus.pix_req && !bus.cmd_req;
`endif
        end else if (state_q == HOLD || (state_q == GAP && cnt_end && lock_q)) begin
            pick_pix = bus.pix_req;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        half_d      = half_q;
        shreg_d     = shreg_q;
        owner_pix_d = owner_pix_q;
        last_d      = last_q;
        lock_d      = lock_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        dc_d        = dc_q;
        cmd_grant_d = 1'b0;
        pix_grant_d = 1'b0;
        cmd_done_d  = 1'b0;
        pix_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                sclk_d = 1'b1;
                cs_n_d = 1'b1;
            end
            SETUP: begin
                if (cnt_end) begin
                    state_d = SHIFT;
                    cnt_d   = 8'd0;
                    half_d  = 4'd0;
                    sclk_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SHIFT: begin
                if (!cnt_end) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (half_q == 4'd15) begin
                    state_d    = GAP;
                    cnt_d      = 8'd0;
                    sclk_d     = 1'b1;
                    cmd_done_d = !owner_pix_q;
                    pix_done_d = owner_pix_q;
                    if (owner_pix_q && last_q) begin
                        lock_d = 1'b0;
                    end
                    cs_n_d = !(lock_q && !(owner_pix_q && last_q));
                end else begin
                    // Odd half ends on a falling SPI_CLK edge: present the next bit.
                    cnt_d  = 8'd0;
                    half_d = half_q + 4'd1;
                    sclk_d = !half_q[0];
                    if (half_q[0]) begin
                        mosi_d  = shreg_q[6];
                        shreg_d = {shreg_q[5:0], 1'b0};
                    end
                end
            end
            GAP: begin
                if (!cnt_end) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (!lock_q) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                end else if (!bus.pix_req) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                sclk_d = 1'b1;
                cs_n_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (pick_cmd || pick_pix) begin
            state_d     = SETUP;
            cnt_d       = 8'd0;
            cs_n_d      = 1'b0;
            sclk_d      = 1'b1;
            owner_pix_d = pick_pix;
            mosi_d      = byte_sel[7];
            shreg_d     = byte_sel[6:0];
            dc_d        = pick_pix ? 1'b1 : bus.cmd_dc;
            last_d      = pick_pix && bus.pix_last;
            cmd_grant_d = pick_cmd;
            pix_grant_d = pick_pix;
            if (pick_pix && !bus.pix_last) begin
                lock_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            half_q      <= 4'd0;
            shreg_q     <= 7'd0;
            owner_pix_q <= 1'b0;
            last_q      <= 1'b0;
            lock_q      <= 1'b0;
            sclk_q      <= 1'b1;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            dc_q        <= 1'b0;
            cmd_grant_q <= 1'b0;
            pix_grant_q <= 1'b0;
            cmd_done_q  <= 1'b0;
            pix_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            shreg_q     <= shreg_d;
            owner_pix_q <= owner_pix_d;
            last_q      <= last_d;
            lock_q      <= lock_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            dc_q        <= dc_d;
            cmd_grant_q <= cmd_grant_d;
            pix_grant_q <= pix_grant_d;
            cmd_done_q  <= cmd_done_d;
            pix_done_q  <= pix_done_d;
        end
    end

`ifdef OLED_ARB_RR_EN
    // Priority flips to the side that was not just granted.
    always_comb begin
        prio_pix_d = prio_pix_q;
        if (pick_cmd) begin
            prio_pix_d = 1'b1;
        end else if (pick_pix) begin
            prio_pix_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_pix_q <= 1'b0;
        end else begin
            prio_pix_q <= prio_pix_d;
        end
    end
`endif

    assign bus.cmd_grant    = cmd_grant_q;
    assign bus.pix_grant    = pix_grant_q;
    assign bus.cmd_done     = cmd_done_q;
    assign bus.pix_done     = pix_done_q;
    assign bus.SPI_CLK      = sclk_q;
    assign bus.SPI_MOSI     = mosi_q;
    assign bus.SPI_CS       = cs_n_q;
    assign bus.data_command = dc_q;
    assign bus.busy         = (state_q != IDLE);

endmodule
